// File: rtl/axi_write_receiver.sv
// axi_write_receiver: slave end of the write-buffer bursts. It accepts one
// address, collects BEATS 32-bit beats into a cache line, hands the line to
// the sink over a valid/ready port, then returns a write response.
// Optional byte strobes are enabled by defining WRITE_RECV_WSTRB_EN, which
// adds the wstrb input and the line_mask output.
module axi_write_receiver #(
    parameter int offset_width = 2,
    parameter int ADDR_W       = 32
) (
    input  logic                            clk,
    input  logic                            rst,
`ifdef WRITE_RECV_WSTRB_EN
    input  logic [3:0]                      wstrb,
    output logic [(1<<offset_width)*4-1:0]  line_mask,
`endif
    input  logic [ADDR_W-1:0]               awaddr,
    input  logic                            awvalid,
    output logic                            awready,
    input  logic [31:0]                     wdata,
    input  logic                            wvalid,
    output logic                            wready,
    input  logic                            wlast,
    output logic                            bvalid,
    input  logic                            bready,
    output logic [1:0]                      bresp,
    output logic [ADDR_W-1:0]               line_addr,
    output logic [(1<<offset_width)*32-1:0] line_data,
    output logic                            line_valid,
    input  logic                            line_ready
);

    localparam int BEATS    = 1 << offset_width;
    localparam int WORD     = BEATS * 32;
    localparam int OFF_BITS = offset_width + 2;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_BITS) - 1);
    localparam logic [offset_width-1:0] LAST_CNT = offset_width'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_DELIVER,
        S_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [offset_width-1:0] cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [WORD-1:0]         data_q, data_d;
    logic [31:0]             beat_data;
`ifdef WRITE_RECV_WSTRB_EN
    logic [BEATS*4-1:0]      mask_q, mask_d;
`endif

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
`ifdef WRITE_RECV_WSTRB_EN
            mask_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
`ifdef WRITE_RECV_WSTRB_EN
            mask_q  <= mask_d;
`endif
        end
    end

    // Next-state and line assembly
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        addr_d  = addr_q;
        data_d  = data_q;
`ifdef WRITE_RECV_WSTRB_EN
        mask_d  = mask_q;
        beat_data = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            if (wstrb[b]) beat_data[b*8 +: 8] = wdata[b*8 +: 8];
        end
`else
        beat_data = wdata;
`endif
        case (state_q)
            S_IDLE: begin
                if (awvalid) begin
                    addr_d  = awaddr & ~OFF_MASK;
                    err_d   = |awaddr[OFF_BITS-1:0];
                    data_d  = '0;
                    cnt_d   = '0;
`ifdef WRITE_RECV_WSTRB_EN
                    mask_d  = '0;
`endif
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (wvalid) begin
                    for (int unsigned i = 0; i < BEATS; i++) begin
                        if (cnt_q == offset_width'(i)) begin
                            data_d[i*32 +: 32] = beat_data;
`ifdef WRITE_RECV_WSTRB_EN
                            mask_d[i*4 +: 4] = wstrb;
`endif
                        end
                    end
                    // Final slot ends the burst whatever wlast says; an early
                    // wlast ends it short. Either irregularity flags an error.
                    if (cnt_q == LAST_CNT) begin
                        if (!wlast) err_d = 1'b1;
                        state_d = S_DELIVER;
                    end else if (wlast) begin
                        err_d   = 1'b1;
                        state_d = S_DELIVER;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DELIVER: begin
                if (line_ready) state_d = S_RESP;
            end
            S_RESP: begin
                if (bready) begin
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        awready    = (state_q == S_IDLE);
        wready     = (state_q == S_DATA);
        line_valid = (state_q == S_DELIVER);
        bvalid     = (state_q == S_RESP);
        bresp      = (state_q == S_RESP && err_q) ? 2'b10 : 2'b00;
        line_addr  = addr_q;
        line_data  = data_q;
`ifdef WRITE_RECV_WSTRB_EN
        line_mask  = mask_q;
`endif
    end

endmodule

// File: doc/axi_write_receiver.md
Name: axi_write_receiver

Overview:
- AXI-style write-burst responder: the slave end of the write bursts issued by the cache write buffer.
- Accepts one address handshake, then BEATS 32-bit data beats (the last flagged by wlast), and assembles them into one cache line.
- Hands the line downstream (memory model / line store) through a valid/ready port, then returns a write response.
- Sits between the write-buffer master and the memory-side line sink.

Parameters:
- offset_width, 2, log2 of 32-bit words per line; BEATS = 1<<offset_width (4), WORD = BEATS*32 (128).
- ADDR_W, 32, address width.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; one clock; reset is synchronous and active-high.
- awaddr  input  ADDR_W  burst start address.
- awvalid  input  1  address valid.
- awready  output  1  address ready.
- wdata  input  32  beat data, word 0 first (bits [31:0] of line).
- wvalid  input  1  beat valid.
- wready  output  1  beat ready.
- wlast  input  1  last-beat flag.
- bvalid  output  1  response valid.
- bready  input  1  response ready.
- bresp  output  2  00 OKAY, 10 SLVERR.
- line_addr  output  ADDR_W  line-aligned address (low offset_width+2 bits zero).
- line_data  output  WORD  assembled line.
- line_valid  output  1  line valid to sink.
- line_ready  input  1  sink accepts line.

Behaviour:
- Reset values: awready=1, wready=0, bvalid=0, bresp=00, line_valid=0, line_addr=0, line_data=0, beat counter=0, error flag=0. Reset mid-burst abandons the burst and returns to IDLE next cycle; no response is issued.
- FSM states: IDLE, DATA, DELIVER, RESP. All outputs are registered or derived from state only; there is no combinational path from input to output.
- IDLE: awready=1. On awvalid&awready, latch line_addr = awaddr with low offset_width+2 bits cleared. Set the error flag if any of those low bits were nonzero. Clear the line register and beat counter. Go to DATA.
- DATA: wready=1. On each wvalid&wready, write wdata into word[cnt] and increment cnt.
  - If wlast is seen with cnt<BEATS-1: set error, leave the remaining words 0, go to DELIVER.
  - At cnt==BEATS-1: go to DELIVER regardless of wlast; a missing wlast sets error.
  - The counter does not wrap; words past BEATS are never written.
- DELIVER: line_valid=1 and line_addr/line_data stable. On line_ready, go to RESP.
  - A line is delivered even on error, with the zero-filled words.
  - line_ready asserted in the same cycle line_valid first rises is accepted (1-cycle DELIVER minimum).
- RESP: bvalid=1, bresp=10 if error else 00. On bready, clear error and return to IDLE; awready is high the next cycle.
- Throughput: a 4-beat burst with all readies high takes 1 (IDLE) + 4 (DATA) + 1 (DELIVER) + 1 (RESP) = 7 cycles, back to back.
- awvalid arriving while not in IDLE is held off (awready=0). wvalid in IDLE/DELIVER/RESP is not accepted (wready=0).

Optional Feature:
- Macro WRITE_RECV_WSTRB_EN.
- With it: adds input wstrb[3:0] and output line_mask[BEATS*4-1:0]. Each accepted beat stores wstrb into the mask bits for word[cnt]; data bytes with strobe 0 are written as 0. Unwritten words have mask 0. Mask resets to 0 and is cleared on address accept.
- Without it: no wstrb or line_mask ports; all data bytes are stored.

Test Plan:
- Aligned burst: awaddr=0x0000_1010, wdata 0x11111111, 0x22222222, 0x33333333, 0x44444444 (wlast on beat 4), all readies high -> line_addr=0x0000_1010, line_data=0x44444444_33333333_22222222_11111111, bresp=00, bvalid 6 cycles after the aw handshake.
- Backpressure: line_ready held low 5 cycles then high; bready low 3 cycles -> line_valid held stable for 6 cycles, bvalid held until bready; awready stays 0 throughout.
- Early wlast on beat 2 (data 0xAAAA0000, 0xBBBB0000) -> line_data=0x00000000_00000000_BBBB0000_AAAA0000, bresp=10.
- Misaligned awaddr=0x0000_2004 -> line_addr=0x0000_2000, bresp=10.
- Reset asserted after beat 2 -> next cycle awready=1, bvalid=0, line_valid=0; a following clean burst responds with OKAY.
- (WRITE_RECV_WSTRB_EN) wstrb=0011 on beat 0, 1111 on the rest -> line_mask=0xFFF3, byte[3:2] of word 0 = 0.
